// File: rtl/axis_read_seq_pkg.sv
// -----------------------------------------------------------------------------
// axis_read_seq_pkg
//
// Shared definitions for the descriptor sequencer that programs the stream
// read engine (axis_read) over the configuration bus.
//
// Contents:
//   DEF_CONFIG_*  default cfg-bus constants. The engine uses the same values,
//                 so both blocks pick them up from this one place.
//   ST_*          bit positions of the one-hot sequencer states.
//   state_e       one-hot state encoding built from those bit positions.
// -----------------------------------------------------------------------------
package axis_read_seq_pkg;

   // Engine configuration bus constants
   localparam int unsigned DEF_CONFIG_ID     = 1;   // ID written to the select address
   localparam int unsigned DEF_CONFIG_ADDR   = 23;  // cfg address that selects the engine
   localparam int unsigned DEF_CONFIG_DATA   = 24;  // cfg address for engine data words
   localparam int unsigned DEF_CONFIG_AWIDTH = 5;
   localparam int unsigned DEF_CONFIG_DWIDTH = 32;

   // One-hot state bit positions
   localparam int unsigned ST_IDLE    = 0;
   localparam int unsigned ST_ID      = 1;
   localparam int unsigned ST_ADDR    = 2;
   localparam int unsigned ST_LEN     = 3;
   localparam int unsigned ST_RUN     = 4;
   localparam int unsigned ST_FIN     = 5;
   localparam int unsigned NUM_STATES = 6;

   typedef enum logic [NUM_STATES-1:0] {
      IDLE   = NUM_STATES'(1) << ST_IDLE,
      S_ID   = NUM_STATES'(1) << ST_ID,
      S_ADDR = NUM_STATES'(1) << ST_ADDR,
      S_LEN  = NUM_STATES'(1) << ST_LEN,
      RUN    = NUM_STATES'(1) << ST_RUN,
      FIN    = NUM_STATES'(1) << ST_FIN
   } state_e;

endpackage

// File: rtl/axis_read_seq.sv
// -----------------------------------------------------------------------------
// axis_read_seq
//
// Descriptor sequencer placed in front of the stream read engine. Accepts a
// (start address, length) descriptor, writes the engine's three-word config
// sequence (ID, address, length) on the shared cfg bus, then counts the
// engine's output beats until the transfer is complete. A new descriptor is
// only taken once the previous transfer has finished, so the engine is never
// reconfigured mid-transfer.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          asynchronous reset, active low
//   desc_addr    descriptor start byte address
//   desc_len     descriptor length in stream words (0 = empty transfer)
//   desc_valid   descriptor offered
//   desc_ready   descriptor accepted when high together with desc_valid
//   cfg_addr     cfg bus address   (0 when cfg_valid is low)
//   cfg_data     cfg bus data      (0 when cfg_valid is low)
//   cfg_valid    cfg word strobe, one word per cycle, no backpressure
//   mon_valid    tap of the engine output valid
//   mon_ready    tap of the downstream ready into the engine
//   busy         high from acceptance until done
//   done         one-cycle completion pulse
//   beat_cnt     beats counted in the current transfer
//   overrun      sticky flag: a beat was seen while no transfer was running
// -----------------------------------------------------------------------------
module axis_read_seq
   import axis_read_seq_pkg::*;
#(
   parameter int unsigned CONFIG_ID     = DEF_CONFIG_ID,
   parameter int unsigned CONFIG_ADDR   = DEF_CONFIG_ADDR,
   parameter int unsigned CONFIG_DATA   = DEF_CONFIG_DATA,
   parameter int unsigned CONFIG_AWIDTH = DEF_CONFIG_AWIDTH,
   parameter int unsigned CONFIG_DWIDTH = DEF_CONFIG_DWIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CONFIG_DWIDTH-1:0] desc_addr,
   input  logic [CONFIG_DWIDTH-1:0] desc_len,
   input  logic                     desc_valid,
   output logic                     desc_ready,
   output logic [CONFIG_AWIDTH-1:0] cfg_addr,
   output logic [CONFIG_DWIDTH-1:0] cfg_data,
   output logic                     cfg_valid,
   input  logic                     mon_valid,
   input  logic                     mon_ready,
   output logic                     busy,
   output logic                     done,
   output logic [CONFIG_DWIDTH-1:0] beat_cnt,
   output logic                     overrun
);

   localparam logic [CONFIG_AWIDTH-1:0] SEL_ADDR  = CONFIG_AWIDTH'(CONFIG_ADDR);
   localparam logic [CONFIG_AWIDTH-1:0] DATA_ADDR = CONFIG_AWIDTH'(CONFIG_DATA);
   localparam logic [CONFIG_DWIDTH-1:0] ID_WORD   = CONFIG_DWIDTH'(CONFIG_ID);

   state_e                     state_q,      state_d;
   logic [CONFIG_DWIDTH-1:0]   addr_q,       addr_d;
   logic [CONFIG_DWIDTH-1:0]   len_q,        len_d;
   logic [CONFIG_DWIDTH-1:0]   cnt_q,        cnt_d;
   logic                       overrun_q,    overrun_d;
   logic                       desc_ready_q, desc_ready_d;
   logic                       busy_q,       busy_d;
   logic                       done_q,       done_d;
   logic                       cfg_valid_q,  cfg_valid_d;
   logic [CONFIG_AWIDTH-1:0]   cfg_addr_q,   cfg_addr_d;
   logic [CONFIG_DWIDTH-1:0]   cfg_data_q,   cfg_data_d;

   logic                       beat_hs;
   logic [CONFIG_DWIDTH-1:0]   cnt_inc;

   // Next-state and next-output logic
   always_comb begin
      beat_hs   = mon_valid & mon_ready;
      cnt_inc   = cnt_q + 1'b1;
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      // Beats are only expected in RUN. The FIN cycle is tolerated because
      // the engine may still present a trailing handshake while we retire.
      overrun_d = overrun_q | (beat_hs & (state_q != RUN) & (state_q != FIN));

      case (state_q)
         IDLE: begin
            // desc_ready_q gates acceptance so nothing is taken in the first
            // cycle after reset release.
            if (desc_valid && desc_ready_q) begin
               addr_d  = desc_addr;
               len_d   = desc_len;
               cnt_d   = '0;
               state_d = (desc_len == '0) ? FIN : S_ID;
            end
         end
         S_ID:   state_d = S_ADDR;
         S_ADDR: state_d = S_LEN;
         S_LEN:  state_d = RUN;
         RUN: begin
            if (beat_hs) begin
               cnt_d = cnt_inc;
               // Equality termination: no wrap, max length 2^DWIDTH-1.
               if (cnt_inc == len_q) begin
                  state_d = FIN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the upcoming state so each state's cfg
      // word is on the bus for exactly the cycle the FSM sits in it.
      desc_ready_d = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == FIN);
      cfg_valid_d  = 1'b0;
      cfg_addr_d   = '0;
      cfg_data_d   = '0;
      case (state_d)
         S_ID: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = SEL_ADDR;
            cfg_data_d  = ID_WORD;
         end
         // The engine shifts data words in: address first, length second.
         S_ADDR: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = DATA_ADDR;
            cfg_data_d  = addr_d;
         end
         S_LEN: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = DATA_ADDR;
            cfg_data_d  = len_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         overrun_q    <= 1'b0;
         desc_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfg_valid_q  <= 1'b0;
         cfg_addr_q   <= '0;
         cfg_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         overrun_q    <= overrun_d;
         desc_ready_q <= desc_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfg_valid_q  <= cfg_valid_d;
         cfg_addr_q   <= cfg_addr_d;
         cfg_data_q   <= cfg_data_d;
      end
   end

   assign desc_ready = desc_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_valid  = cfg_valid_q;
   assign cfg_addr   = cfg_addr_q;
   assign cfg_data   = cfg_data_q;
   assign beat_cnt   = cnt_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_axis_read_seq.sv
// -----------------------------------------------------------------------------
// tb_axis_read_seq
//
// Self-checking bench for axis_read_seq. Outputs are compared every cycle,
// 1 ns after the rising edge, against a reference model that reasons in
// terms of edge numbers: the edge a descriptor is accepted, the edges on
// which beats count, and the edge on which the last beat lands.
// -----------------------------------------------------------------------------
module tb_axis_read_seq;

   localparam int INF = 32'h3fff_ffff;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] desc_addr = '0;
   logic [31:0] desc_len = '0;
   logic        desc_valid = 1'b0;
   logic        desc_ready;
   logic [4:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_valid;
   logic        mon_valid = 1'b0;
   logic        mon_ready = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] beat_cnt;
   logic        overrun;

   always #5 clk = ~clk;

   axis_read_seq dut (
      .clk        (clk),
      .rst        (rst),
      .desc_addr  (desc_addr),
      .desc_len   (desc_len),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_valid  (cfg_valid),
      .mon_valid  (mon_valid),
      .mon_ready  (mon_ready),
      .busy       (busy),
      .done       (done),
      .beat_cnt   (beat_cnt),
      .overrun    (overrun)
   );

   int n_cmp  = 0;
   int n_err  = 0;
   int edge_n = 0;

   // Reference model state (edge numbers are bench edge counts)
   bit          m_busy      = 1'b0;
   bit          m_overrun   = 1'b0;
   bit          m_after_rst = 1'b1;
   int          m_t         = 0;    // acceptance edge
   int          m_f         = -1;   // edge on which the last beat landed (or acceptance for len 0)
   int          m_ok_edge   = INF;  // earliest edge at which a descriptor may be accepted
   logic [31:0] m_addr      = '0;
   logic [31:0] m_len       = '0;
   logic [31:0] m_cnt       = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      m_busy      = 1'b0;
      m_overrun   = 1'b0;
      m_after_rst = 1'b1;
      m_cnt       = '0;
      m_len       = '0;
      m_f         = -1;
      m_ok_edge   = INF;
   endtask

   // Applies the inputs seen at edge edge_n to the model.
   task automatic model_edge();
      bit hs;
      bit acc;
      bit fin_edge;
      if (rst) begin
         if (m_after_rst) begin
            m_ok_edge   = edge_n + 1;
            m_after_rst = 1'b0;
         end
         hs  = mon_valid & mon_ready;
         acc = 1'b0;
         if (!m_busy && edge_n >= m_ok_edge && desc_valid) begin
            m_busy = 1'b1;
            m_t    = edge_n;
            m_addr = desc_addr;
            m_len  = desc_len;
            m_cnt  = '0;
            m_f    = (desc_len == 0) ? edge_n : -1;
            acc    = 1'b1;
         end
         fin_edge = m_busy && (m_f >= 0) && (edge_n == m_f + 1);
         if (hs) begin
            if (m_busy && !acc && edge_n >= m_t + 4 && m_f < 0) begin
               m_cnt = m_cnt + 1;
               if (m_cnt == m_len) m_f = edge_n;
            end else if (!fin_edge) begin
               m_overrun = 1'b1;
            end
         end
         if (fin_edge) begin
            m_busy    = 1'b0;
            m_ok_edge = edge_n + 1;
         end
      end
   endtask

   task automatic compare_all();
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        ev;
      int          k;
      ea = '0;
      ed = '0;
      ev = 1'b0;
      k  = edge_n - m_t;
      if (m_busy && m_len != 0) begin
         if (k == 0) begin
            ev = 1'b1; ea = 5'd23; ed = 32'd1;
         end else if (k == 1) begin
            ev = 1'b1; ea = 5'd24; ed = m_addr;
         end else if (k == 2) begin
            ev = 1'b1; ea = 5'd24; ed = m_len;
         end
      end
      chk("desc_ready", 32'(desc_ready), 32'(!m_busy && (edge_n + 1 >= m_ok_edge)));
      chk("cfg_valid",  32'(cfg_valid),  32'(ev));
      chk("cfg_addr",   32'(cfg_addr),   32'(ea));
      chk("cfg_data",   cfg_data,        ed);
      chk("busy",       32'(busy),       32'(m_busy));
      chk("done",       32'(done),       32'(m_busy && m_f == edge_n));
      chk("beat_cnt",   beat_cnt,        m_cnt);
      chk("overrun",    32'(overrun),    32'(m_overrun));
   endtask

   task automatic step();
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
      compare_all();
   endtask

   // mode 0: ready tied high, valid only in the beat window
   // mode 1: valid held in the beat window, ready toggles randomly
   // mode 2: both random in every phase (stray beats included)
   task automatic drive_mon(input int mode, input bit beat_phase);
      case (mode)
         0: begin
            mon_valid = beat_phase;
            mon_ready = 1'b1;
         end
         1: begin
            mon_valid = beat_phase;
            mon_ready = 1'($urandom_range(0, 1));
         end
         default: begin
            mon_valid = 1'($urandom_range(0, 1));
            mon_ready = 1'($urandom_range(0, 1));
         end
      endcase
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] l, input int mode,
                        output int acc_e);
      bit took;
      int tries;
      desc_addr  = a;
      desc_len   = l;
      desc_valid = 1'b1;
      acc_e      = -1;
      tries      = 0;
      while (acc_e < 0 && tries < 60) begin
         drive_mon(mode, 1'b0);
         took = desc_ready;
         step();
         if (took) acc_e = edge_n;
         tries++;
      end
      desc_valid = 1'b0;
      desc_addr  = $urandom;
      desc_len   = $urandom;
      if (acc_e < 0) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // Offers a descriptor, feeds beats and returns in the done cycle.
   task automatic run_desc(input logic [31:0] a, input logic [31:0] l, input int mode,
                           output int acc_e, output int done_e);
      int k;
      int budget;
      offer(a, l, mode, acc_e);
      done_e = -1;
      if (acc_e >= 0) begin
         if (done) done_e = edge_n;
         k      = 0;
         budget = 20 * int'(l) + 100;
         while (done_e < 0 && k < budget) begin
            drive_mon(mode, k >= 3);
            step();
            k++;
            if (done) done_e = edge_n;
         end
         if (done_e < 0) chk("done_timeout", 32'd0, 32'd1);
      end
      mon_valid = 1'b0;
      $display("desc addr=0x%08h len=%0d mode=%0d accepted@%0d done@%0d beats=%0d overrun=%0d",
               a, l, mode, acc_e, done_e, beat_cnt, overrun);
   endtask

   initial begin
      int a1, d1, a2, d2;
      logic [31:0] rl;
      int rm;

      // Reset values
      #1 rst = 1'b0;
      model_reset();
      #1 compare_all();
      repeat (3) step();
      rst = 1'b1;
      step();

      // Basic transfer: 16 beats, ready tied high
      run_desc(32'h1000_0000, 32'd16, 0, a1, d1);
      chk("t16_beat_cnt", beat_cnt, 32'd16);
      chk("t16_overrun", 32'(overrun), 32'd0);
      mon_valid = 1'b0;
      repeat (2) step();

      // Zero length: done right after acceptance, no cfg words
      run_desc(32'h0000_abcd, 32'd0, 0, a1, d1);
      chk("len0_done_lat", 32'(d1 - a1), 32'd0);
      step();
      chk("len0_ready_back", 32'(desc_ready), 32'd1);

      // Ready toggling 50 %
      run_desc(32'h2000_0040, 32'd8, 1, a1, d1);
      chk("t8_beat_cnt", beat_cnt, 32'd8);

      // Back-to-back descriptors: second taken two edges after the last beat
      run_desc(32'h3000_0000, 32'd5, 0, a1, d1);
      run_desc(32'h3000_1000, 32'd3, 0, a2, d2);
      chk("b2b_gap", 32'(a2 - d1), 32'd2);

      // Stray beat in IDLE sets the sticky overrun
      mon_valid = 1'b0;
      step();
      mon_valid = 1'b1;
      mon_ready = 1'b1;
      step();
      mon_valid = 1'b0;
      chk("ovr_set", 32'(overrun), 32'd1);
      run_desc(32'h4000_0000, 32'd4, 0, a1, d1);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Reset in the middle of the cfg sequence
      offer(32'h5555_0000, 32'd6, 0, a1);
      mon_valid = 1'b0;
      step();
      chk("pre_rst_cfg_valid", 32'(cfg_valid), 32'd1);
      rst = 1'b0;
      model_reset();
      #1 compare_all();
      chk("rst_cfg_drop", 32'(cfg_valid), 32'd0);
      chk("rst_ovr_clear", 32'(overrun), 32'd0);
      repeat (2) step();
      rst = 1'b1;
      step();
      run_desc(32'h6000_0000, 32'd4, 0, a1, d1);
      chk("post_rst_cnt", beat_cnt, 32'd4);

      // Randomized descriptors, beat patterns and idle gaps
      repeat (40) begin
         rl = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
         rm = int'($urandom_range(0, 2));
         run_desc($urandom, rl, rm, a1, d1);
         repeat ($urandom_range(0, 3)) begin
            drive_mon(rm, 1'b0);
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
